// File: rtl/token_dispense_sequencer_pkg.sv
// Shared constants for the token dispense sequencer: colour codes, FSM
// encodings, decoder response codes and the colour-scan helper.
package token_pkg;

  localparam logic [1:0] RED   = 2'b00;
  localparam logic [1:0] BLUE  = 2'b01;
  localparam logic [1:0] GREEN = 2'b10;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_DISPENSE = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  localparam logic [7:0] SUCCESS = 8'b00000011;
  localparam logic [7:0] ERROR   = 8'b00000010;

  typedef struct packed {
    logic       found;
    logic [1:0] colour;
    logic [7:0] count;
  } colour_pick_t;

  // First colour at or after 'first' (red, blue, green order) with a nonzero count.
  function automatic colour_pick_t pick_colour(input logic [1:0] first,
                                               input logic [7:0] r,
                                               input logic [7:0] b,
                                               input logic [7:0] g);
    colour_pick_t p;
    p = '0;
    if (first == RED && r != 8'd0) begin
      p.found  = 1'b1;
      p.colour = RED;
      p.count  = r;
    end else if (first[1] == 1'b0 && b != 8'd0) begin
      p.found  = 1'b1;
      p.colour = BLUE;
      p.count  = b;
    end else if (first != 2'b11 && g != 8'd0) begin
      p.found  = 1'b1;
      p.colour = GREEN;
      p.count  = g;
    end
    return p;
  endfunction

  function automatic logic [7:0] response_code(input logic result_ok);
    return result_ok ? SUCCESS : ERROR;
  endfunction

endpackage

// File: rtl/token_dispense_sequencer_if.sv
// Command/status bundle between the input decoder (master) and the
// dispense sequencer (slave).
interface token_dispense_sequencer_if;
  logic       start;
  logic [7:0] red_count;
  logic [7:0] blue_count;
  logic [7:0] green_count;
  logic       abort;
  logic       token_seen;
  logic       motor_en;
  logic [1:0] colour_sel;
  logic       busy;
  logic       done;
  logic       result_ok;
  logic       fault;
  logic [7:0] remaining;

  modport master (
    output start, red_count, blue_count, green_count, abort, token_seen,
    input  motor_en, colour_sel, busy, done, result_ok, fault, remaining
  );

  modport slave (
    input  start, red_count, blue_count, green_count, abort, token_seen,
    output motor_en, colour_sel, busy, done, result_ok, fault, remaining
  );
endinterface

// File: rtl/token_dispense_sequencer_delay_timer.sv
// Up-counting interval timer; load clears the count and captures a new limit,
// expired flags the last cycle of the loaded interval.
module delay_timer #(
  parameter int TW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [TW-1:0] limit,
  output logic          expired
);

  logic [TW-1:0] count_q, count_d;
  logic [TW-1:0] limit_q, limit_d;

  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    if (load) begin
      count_d = '0;
      limit_d = limit;
    end else if (en) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      limit_q <= '0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  // A count of limit-1 is the limit-th cycle since the load.
  assign expired = (count_q == limit_q - TW'(1));

endmodule

// File: rtl/token_dispense_sequencer.sv
// Sequences the shared dispenser motor and colour gate through the latched
// red/blue/green counts and reports a pass/fail result to the decoder.
//
// state    | meaning
// IDLE     | waiting for start
// SELECT   | colour gate settling, motor off
// DISPENSE | motor on, waiting for a token or timeout
// GAP      | motor off after a token
// DONE     | success, done/result_ok pulse issued next cycle
// FAULT    | timeout, held busy until abort
module token_dispense_sequencer
  import token_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int GAP_CYCLES     = 500,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TW             = 17
) (
  input logic                        clk,
  input logic                        rst,
  token_dispense_sequencer_if.slave  bus
);

  logic [2:0] state_q, state_d;
  logic [7:0] red_q, red_d, blue_q, blue_d, green_q, green_d;
  logic [1:0] colour_sel_q, colour_sel_d;
  logic [7:0] remaining_q, remaining_d;
  logic       motor_en_q, motor_en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       result_ok_q, result_ok_d;
  logic       fault_q, fault_d;

  logic          tmr_en, tmr_load, tmr_expired;
  logic [TW-1:0] tmr_limit;
  colour_pick_t  pick;

  always_comb begin
    state_d      = state_q;
    red_d        = red_q;
    blue_d       = blue_q;
    green_d      = green_q;
    colour_sel_d = colour_sel_q;
    remaining_d  = remaining_q;
    result_ok_d  = result_ok_q;
    fault_d      = fault_q;
    done_d       = 1'b0;
    pick         = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          red_d        = bus.red_count;
          blue_d       = bus.blue_count;
          green_d      = bus.green_count;
          result_ok_d  = 1'b0;
          pick         = pick_colour(RED, bus.red_count, bus.blue_count, bus.green_count);
          colour_sel_d = pick.colour;
          remaining_d  = pick.count;
          state_d      = pick.found ? S_SELECT : S_DONE;
        end
      end
      S_SELECT: begin
        if (tmr_expired) state_d = S_DISPENSE;
      end
      S_DISPENSE: begin
        if (bus.token_seen) begin
          if (remaining_q != 8'd0) remaining_d = remaining_q - 8'd1;
          state_d = S_GAP;
        end else if (tmr_expired) begin
          state_d     = S_FAULT;
          fault_d     = 1'b1;
          done_d      = 1'b1;
          result_ok_d = 1'b0;
        end
      end
      S_GAP: begin
        if (tmr_expired) begin
          if (remaining_q != 8'd0) begin
            state_d = S_DISPENSE;
          end else begin
            pick = pick_colour(colour_sel_q + 2'd1, red_q, blue_q, green_q);
            if (pick.found) begin
              colour_sel_d = pick.colour;
              remaining_d  = pick.count;
              state_d      = S_SELECT;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        done_d      = 1'b1;
        result_ok_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_FAULT: begin
        if (bus.abort) begin
          fault_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the active state decided this cycle.
    if (bus.abort && (state_q == S_SELECT || state_q == S_DISPENSE || state_q == S_GAP)) begin
      state_d     = S_IDLE;
      remaining_d = remaining_q;
      done_d      = 1'b1;
      result_ok_d = 1'b0;
      fault_d     = 1'b0;
    end

    motor_en_d = (state_d == S_DISPENSE);
    busy_d     = (state_d != S_IDLE);
  end

  always_comb begin
    case (state_d)
      S_SELECT: tmr_limit = TW'(SETTLE_CYCLES);
      S_GAP:    tmr_limit = TW'(GAP_CYCLES);
      default:  tmr_limit = TW'(TIMEOUT_CYCLES);
    endcase
    tmr_load = (state_d != state_q);
    tmr_en   = (state_q == S_SELECT) || (state_q == S_DISPENSE) || (state_q == S_GAP);
  end

  delay_timer #(.TW(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (tmr_en),
    .load    (tmr_load),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      red_q        <= '0;
      blue_q       <= '0;
      green_q      <= '0;
      colour_sel_q <= RED;
      remaining_q  <= '0;
      motor_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_ok_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      red_q        <= red_d;
      blue_q       <= blue_d;
      green_q      <= green_d;
      colour_sel_q <= colour_sel_d;
      remaining_q  <= remaining_d;
      motor_en_q   <= motor_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_ok_q  <= result_ok_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.motor_en   = motor_en_q;
  assign bus.colour_sel = colour_sel_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result_ok  = result_ok_q;
  assign bus.fault      = fault_q;
  assign bus.remaining  = remaining_q;

endmodule

// File: tb/tb_token_dispense_sequencer.sv
// Bench for token_dispense_sequencer: directed and random dispense commands
// compared against a timeline model built from the command and token delays.
module tb_token_dispense_sequencer;
  import token_pkg::*;

  localparam int SETTLE  = 4;
  localparam int GAP     = 3;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   dly[$];

  token_dispense_sequencer_if bus();

  token_dispense_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TW            (17)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " motor_en"},   32'(bus.motor_en),   0);
    check({tag, " colour_sel"}, 32'(bus.colour_sel), 0);
    check({tag, " busy"},       32'(bus.busy),       0);
    check({tag, " done"},       32'(bus.done),       0);
    check({tag, " result_ok"},  32'(bus.result_ok),  0);
    check({tag, " fault"},      32'(bus.fault),      0);
    check({tag, " remaining"},  32'(bus.remaining),  0);
  endtask

  task automatic fill_dly(input int v);
    dly = {};
    repeat (24) dly.push_back(v);
  endtask

  // Token delay d means token_seen lands in motor-on cycle d (0-based);
  // d >= TIMEOUT means no token for that window.
  task automatic run_cmd(input string name, input int r, input int b, input int g,
                         input int abort_win, input int abort_k, input bit stray);
    int cnt[3];
    int exp_col[$], exp_len[$], exp_rem[$], wstart[$];
    int obs_col[$], obs_len[$], obs_rem[$];
    int t, w, done_at, s, k, last, exp_rem_end;
    bit exp_fault, aborted, in_win, got_done, busy_bad;
    logic d_ok, d_fault, d_busy;
    logic [7:0] d_rem;

    cnt[0] = r; cnt[1] = b; cnt[2] = g;
    t = 0; w = 0; exp_fault = 0;
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < cnt[c] && !exp_fault; j++) begin
        if (j == 0) t += SETTLE;
        exp_col.push_back(c);
        exp_rem.push_back(cnt[c] - j);
        wstart.push_back(t + 1);
        if (dly[w] >= TIMEOUT) begin
          exp_len.push_back(TIMEOUT);
          t += TIMEOUT;
          exp_fault = 1;
        end else begin
          exp_len.push_back(dly[w] + 1);
          t += dly[w] + 1 + GAP;
        end
        w++;
      end
    end
    done_at = exp_fault ? t + 1 : t + 2;
    exp_rem_end = exp_fault ? exp_rem[exp_rem.size() - 1] : 0;
    aborted = (abort_win >= 0);
    if (aborted) begin
      while (exp_len.size() > abort_win + 1) begin
        void'(exp_len.pop_back());
        void'(exp_col.pop_back());
        void'(exp_rem.pop_back());
      end
      exp_len[abort_win] = abort_k + 1;
      exp_fault   = 0;
      done_at     = wstart[abort_win] + abort_k + 1;
      exp_rem_end = exp_rem[abort_win];
    end

    @(negedge clk);
    bus.start = 1'b1;
    bus.red_count = 8'(r); bus.blue_count = 8'(b); bus.green_count = 8'(g);
    @(negedge clk);
    s = 1; k = 0; last = -1; in_win = 0; got_done = 0; busy_bad = 0;
    d_ok = 1'bx; d_fault = 1'bx; d_busy = 1'bx; d_rem = 'x;
    while (!got_done && s < 800) begin
      bus.start = 1'b0; bus.token_seen = 1'b0; bus.abort = 1'b0;
      if (bus.done === 1'b1) begin
        got_done = 1; last = s;
        d_ok = bus.result_ok; d_fault = bus.fault; d_busy = bus.busy; d_rem = bus.remaining;
      end else begin
        if (bus.busy !== 1'b1) busy_bad = 1;
        if (bus.motor_en === 1'b1) begin
          if (!in_win) begin
            obs_col.push_back(int'(bus.colour_sel));
            obs_rem.push_back(int'(bus.remaining));
            obs_len.push_back(0);
            k = 0; in_win = 1;
          end else begin
            k++;
          end
          w = obs_len.size() - 1;
          obs_len[w] = obs_len[w] + 1;
          if (k == dly[w]) bus.token_seen = 1'b1;
          if (w == abort_win && k == abort_k) begin
            bus.abort = 1'b1;
            bus.token_seen = 1'b1;
          end
        end else begin
          in_win = 0;
          if (stray) bus.token_seen = ($urandom_range(1, 0) == 1);
        end
        if (stray && bus.busy === 1'b1 && $urandom_range(3, 0) == 0) begin
          bus.start = 1'b1;
          bus.red_count = 8'($urandom); bus.blue_count = 8'($urandom);
          bus.green_count = 8'($urandom);
        end
        @(negedge clk);
        s++;
      end
    end
    bus.start = 1'b0; bus.token_seen = 1'b0; bus.abort = 1'b0;

    check({name, " done_seen"},  32'(got_done), 1);
    check({name, " done_cycle"}, last, done_at);
    check({name, " result_ok"},  32'(d_ok),    32'(!exp_fault && !aborted));
    check({name, " fault"},      32'(d_fault), 32'(exp_fault));
    check({name, " busy_at_done"}, 32'(d_busy), 32'(exp_fault));
    check({name, " remaining_at_done"}, 32'(d_rem), exp_rem_end);
    check({name, " busy_held"},  32'(busy_bad), 0);
    check({name, " windows"},    obs_len.size(), exp_len.size());
    for (int i = 0; i < obs_len.size() && i < exp_len.size(); i++) begin
      check($sformatf("%s win%0d colour", name, i), obs_col[i], exp_col[i]);
      check($sformatf("%s win%0d length", name, i), obs_len[i], exp_len[i]);
      check($sformatf("%s win%0d remaining", name, i), obs_rem[i], exp_rem[i]);
    end

    @(negedge clk);
    check({name, " done_one_cycle"}, 32'(bus.done), 0);
    if (exp_fault) begin
      repeat (3) @(negedge clk);
      check({name, " fault_sticky"}, 32'(bus.fault), 1);
      check({name, " fault_busy"},   32'(bus.busy),  1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check({name, " fault_clear"},  32'(bus.fault), 0);
      check({name, " fault_unbusy"}, 32'(bus.busy),  0);
    end
    check({name, " result_ok_held"}, 32'(bus.result_ok), 32'(!exp_fault && !aborted));
  endtask

  initial begin
    int n, rr, bb, gg;
    bus.start = 1'b0; bus.abort = 1'b0; bus.token_seen = 1'b0;
    bus.red_count = '0; bus.blue_count = '0; bus.green_count = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    fill_dly(5);
    run_cmd("r2b0g1", 2, 0, 1, -1, 0, 0);

    fill_dly(5);
    run_cmd("all_zero", 0, 0, 0, -1, 0, 0);

    fill_dly(TIMEOUT + 10);
    run_cmd("timeout", 1, 0, 0, -1, 0, 0);

    fill_dly(2);
    run_cmd("abort_b3", 0, 3, 0, 1, 2, 0);

    fill_dly(TIMEOUT - 1);
    run_cmd("coincident", 0, 1, 1, -1, 0, 1);

    for (int it = 0; it < 6; it++) begin
      dly = {};
      repeat (24) dly.push_back($urandom_range(TIMEOUT - 1, 0));
      if ($urandom_range(4, 0) == 0) dly[$urandom_range(5, 0)] = TIMEOUT + 3;
      rr = $urandom_range(3, 0); bb = $urandom_range(3, 0); gg = $urandom_range(3, 0);
      run_cmd($sformatf("rand%0d", it), rr, bb, gg, -1, 0, 1);
    end

    fill_dly(TIMEOUT + 10);
    @(negedge clk);
    bus.start = 1'b1; bus.red_count = 8'd1; bus.blue_count = 8'd0; bus.green_count = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.motor_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_motor_on", 32'(bus.motor_en), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_motor", 32'(bus.motor_en), 0);
    check_idle_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stays_idle", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
